life_controller: RTL and testbench

LIFE_CONTROLLER -- requirements
Module: life_controller

---
 rtl/life_controller_pkg.sv | 18 +
 rtl/life_controller_if.sv | 39 +++
 rtl/life_controller_gen_tick.sv | 33 +++
 rtl/life_controller.sv | 145 ++++++++++++++
 tb/tb_life_controller.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/life_controller_pkg.sv
// Shared types and default sizing for the Game-of-Life grid controller.
//   DEF_ROWS / DEF_COLS : default grid dimensions
//   DEF_TICK_DIV        : default clock cycles per generation while running
//   life_state_e        : controller FSM encoding
package life_pkg;

    localparam int unsigned DEF_ROWS     = 16;
    localparam int unsigned DEF_COLS     = 16;
    localparam int unsigned DEF_TICK_DIV = 25_000_000;

    typedef enum logic [1:0] {
        EDIT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        CLEAR = 2'd3
    } life_state_e;

endpackage

// File: rtl/life_controller_if.sv
// User-command / cell-array bus of the life controller.
//   Start, Stop, Step, Clear      : command pulses (master -> slave)
//   Up, Down, Left, Right         : cursor-move pulses (master -> slave)
//   Draw, Erase                   : cell write pulses (master -> slave)
//   RowSelect, ColumnSelect       : cell array write enables (slave -> master)
//   state, Input                  : generation strobe and write data (slave -> master)
//   CursorRow, CursorCol, Running, GenCount : status (slave -> master)
interface life_if
    import life_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned COLS = DEF_COLS
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    logic            Start, Stop, Step, Clear;
    logic            Up, Down, Left, Right;
    logic            Draw, Erase;
    logic [ROWS-1:0] RowSelect;
    logic [COLS-1:0] ColumnSelect;
    logic            state;
    logic            Input;
    logic [RW-1:0]   CursorRow;
    logic [CW-1:0]   CursorCol;
    logic            Running;
    logic [15:0]     GenCount;

    modport master (
        output Start, Stop, Step, Clear, Up, Down, Left, Right, Draw, Erase,
        input  RowSelect, ColumnSelect, state, Input, CursorRow, CursorCol, Running, GenCount
    );

    modport slave (
        input  Start, Stop, Step, Clear, Up, Down, Left, Right, Draw, Erase,
        output RowSelect, ColumnSelect, state, Input, CursorRow, CursorCol, Running, GenCount
    );

endinterface

// File: rtl/life_controller_gen_tick.sv
// Generation tick counter: counts while enabled, synchronous clear,
// combinational terminal-count pulse on the cycle the count equals TICK_DIV-1.
//   Clock, Reset : clock, async active-high reset
//   en           : count enable
//   clr          : synchronous clear (wins over en)
//   tc_c         : terminal count (en && count == TICK_DIV-1)
module gen_tick #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic tc_c
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tc_c = en && (cnt_q == CNT_W'(TICK_DIV - 1));

    // Wraps to zero on terminal count
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/life_controller.sv
// Game-of-Life grid controller: edit cursor, draw/erase writes, clear, single
// step and free-running generation strobe towards the per-cell manager array.
// Holds no cell storage.
//   Clock, Reset : clock, async active-high reset
//   bus          : life_if slave (commands in; selects, strobe, status out)
module life_controller
    import life_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic  Clock,
    input  logic  Reset,
    life_if.slave bus
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    life_state_e     fsm_q, fsm_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [15:0]     gen_q, gen_d;
    logic [ROWS-1:0] rsel_q, rsel_d;
    logic [COLS-1:0] csel_q, csel_d;
    logic            strobe_q, strobe_d;
    logic            din_q, din_d;
    logic            running_q, running_d;

    logic cmd_clear, cmd_stop, cmd_start, cmd_step;
    logic tick_tc_c;

    // Only the highest-priority asserted command acts
    assign cmd_clear = bus.Clear;
    assign cmd_stop  = !bus.Clear && bus.Stop;
    assign cmd_start = !bus.Clear && !bus.Stop && bus.Start;
    assign cmd_step  = !bus.Clear && !bus.Stop && !bus.Start && bus.Step;

    // Counter sits at zero outside RUN and is dropped on the leaving cycle
    gen_tick #(.TICK_DIV(TICK_DIV)) u_gen_tick (
        .Clock (Clock),
        .Reset (Reset),
        .en    (fsm_q == RUN),
        .clr   ((fsm_q != RUN) || cmd_stop || cmd_clear),
        .tc_c  (tick_tc_c)
    );

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fsm_q     <= EDIT;
            row_q     <= '0;
            col_q     <= '0;
            gen_q     <= '0;
            rsel_q    <= '0;
            csel_q    <= '0;
            strobe_q  <= 1'b0;
            din_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            row_q     <= row_d;
            col_q     <= col_d;
            gen_q     <= gen_d;
            rsel_q    <= rsel_d;
            csel_q    <= csel_d;
            strobe_q  <= strobe_d;
            din_q     <= din_d;
            running_q <= running_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        fsm_d    = fsm_q;
        row_d    = row_q;
        col_d    = col_q;
        gen_d    = gen_q + 16'(strobe_q);
        rsel_d   = '0;
        csel_d   = '0;
        strobe_d = 1'b0;
        din_d    = 1'b0;

        case (fsm_q)
            EDIT: begin
                if (cmd_start) begin
                    fsm_d = RUN;
                end else if (cmd_step) begin
                    fsm_d    = STEP;
                    strobe_d = 1'b1;
                end
                if (!cmd_clear) begin
                    // Opposing pulses cancel per axis; each axis wraps
                    if (bus.Up && !bus.Down) begin
                        row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
                    end else if (bus.Down && !bus.Up) begin
                        row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                    end
                    if (bus.Left && !bus.Right) begin
                        col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
                    end else if (bus.Right && !bus.Left) begin
                        col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
                    end
                    // Write at the pre-move cursor; never alongside a step strobe
                    if (!cmd_step && (bus.Draw || bus.Erase)) begin
                        rsel_d = ROWS'(1) << row_q;
                        csel_d = COLS'(1) << col_q;
                        din_d  = !bus.Erase;
                    end
                end
            end
            RUN: begin
                if (cmd_stop) begin
                    fsm_d = EDIT;
                end else if (tick_tc_c) begin
                    strobe_d = 1'b1;
                end
            end
            STEP:    fsm_d = EDIT;
            CLEAR:   fsm_d = EDIT;
            default: fsm_d = EDIT;
        endcase

        if (cmd_clear) begin
            fsm_d    = CLEAR;
            rsel_d   = '1;
            csel_d   = '1;
            din_d    = 1'b0;
            strobe_d = 1'b0;
            gen_d    = '0;
        end
    end

    assign running_d = (fsm_d == RUN);

    assign bus.RowSelect    = rsel_q;
    assign bus.ColumnSelect = csel_q;
    assign bus.state        = strobe_q;
    assign bus.Input        = din_q;
    assign bus.CursorRow    = row_q;
    assign bus.CursorCol    = col_q;
    assign bus.Running      = running_q;
    assign bus.GenCount     = gen_q;

endmodule

// File: tb/tb_life_controller.sv
// Directed self-checking bench for life_controller (ROWS=COLS=4, TICK_DIV=4).
module tb_life_controller;

    localparam int unsigned ROWS     = 4;
    localparam int unsigned COLS     = 4;
    localparam int unsigned TICK_DIV = 4;

    // Command bit positions for the pulse task
    localparam int unsigned B_START = 0;
    localparam int unsigned B_STOP  = 1;
    localparam int unsigned B_STEP  = 2;
    localparam int unsigned B_CLEAR = 3;
    localparam int unsigned B_UP    = 4;
    localparam int unsigned B_DOWN  = 5;
    localparam int unsigned B_LEFT  = 6;
    localparam int unsigned B_RIGHT = 7;
    localparam int unsigned B_DRAW  = 8;
    localparam int unsigned B_ERASE = 9;

    logic Clock;
    logic Reset;
    int   n_checks;
    int   n_errors;

    life_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    life_controller #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic [9:0] c);
        bus.Start = c[B_START];
        bus.Stop  = c[B_STOP];
        bus.Step  = c[B_STEP];
        bus.Clear = c[B_CLEAR];
        bus.Up    = c[B_UP];
        bus.Down  = c[B_DOWN];
        bus.Left  = c[B_LEFT];
        bus.Right = c[B_RIGHT];
        bus.Draw  = c[B_DRAW];
        bus.Erase = c[B_ERASE];
    endtask

    // Hold the commands for one cycle, then sample the resulting outputs
    task automatic pulse(input logic [9:0] c);
        drive(c);
        tick();
        drive('0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".rsel"}, 32'(bus.RowSelect), 32'h0);
        check({tag, ".csel"}, 32'(bus.ColumnSelect), 32'h0);
        check({tag, ".input"}, 32'(bus.Input), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive('0);
        Reset = 1'b1;
        #12;
        check_idle("reset");
        check("reset.state", 32'(bus.state), 32'h0);
        check("reset.running", 32'(bus.Running), 32'h0);
        check("reset.gen", 32'(bus.GenCount), 32'h0);
        check("reset.row", 32'(bus.CursorRow), 32'h0);
        check("reset.col", 32'(bus.CursorCol), 32'h0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        tick();

        // Cursor wrap and draw at (3,3)
        pulse(10'(1 << B_UP));
        check("up.row", 32'(bus.CursorRow), 32'd3);
        check("up.col", 32'(bus.CursorCol), 32'd0);
        pulse(10'(1 << B_LEFT));
        check("left.col", 32'(bus.CursorCol), 32'd3);
        pulse(10'(1 << B_DRAW));
        check("draw.rsel", 32'(bus.RowSelect), 32'h8);
        check("draw.csel", 32'(bus.ColumnSelect), 32'h8);
        check("draw.input", 32'(bus.Input), 32'h1);
        check("draw.state", 32'(bus.state), 32'h0);
        tick();
        check_idle("draw.after");

        // Wrap forward to (0,0), then Draw+Erase with a move: erase at pre-move cursor
        pulse(10'((1 << B_DOWN) | (1 << B_RIGHT)));
        check("wrapfw.row", 32'(bus.CursorRow), 32'd0);
        check("wrapfw.col", 32'(bus.CursorCol), 32'd0);
        pulse(10'((1 << B_DRAW) | (1 << B_ERASE) | (1 << B_RIGHT) | (1 << B_UP) | (1 << B_DOWN)));
        check("erase.rsel", 32'(bus.RowSelect), 32'h1);
        check("erase.csel", 32'(bus.ColumnSelect), 32'h1);
        check("erase.input", 32'(bus.Input), 32'h0);
        check("erase.row", 32'(bus.CursorRow), 32'd0);
        check("erase.col", 32'(bus.CursorCol), 32'd1);
        pulse(10'((1 << B_UP) | (1 << B_LEFT) | (1 << B_RIGHT)));
        check("diag.row", 32'(bus.CursorRow), 32'd3);
        check("diag.col", 32'(bus.CursorCol), 32'd1);

        // Run: strobe on cycles 4, 8, 12 after entry
        pulse(10'(1 << B_START));
        check("run.running", 32'(bus.Running), 32'h1);
        check("run.state0", 32'(bus.state), 32'h0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) drive(10'(1 << B_START));
            tick();
            drive('0);
            check($sformatf("run.state%0d", k), 32'(bus.state), (k % 4 == 0) ? 32'h1 : 32'h0);
        end
        tick();
        check("run.gen3", 32'(bus.GenCount), 32'd3);
        check("run.still", 32'(bus.Running), 32'h1);
        pulse(10'(1 << B_DRAW));
        check_idle("run.draw");
        check("run.cursor", 32'(bus.CursorCol), 32'd1);

        // Stop at tick count 2: no strobe follows
        pulse(10'(1 << B_STOP));
        check("stop.running", 32'(bus.Running), 32'h0);
        check("stop.state", 32'(bus.state), 32'h0);
        tick();
        check("stop.state1", 32'(bus.state), 32'h0);
        tick();
        check("stop.state2", 32'(bus.state), 32'h0);
        check("stop.gen", 32'(bus.GenCount), 32'd3);

        // Single step
        pulse(10'(1 << B_STEP));
        check("step.state", 32'(bus.state), 32'h1);
        check("step.running", 32'(bus.Running), 32'h0);
        check_idle("step");
        tick();
        check("step.state_off", 32'(bus.state), 32'h0);
        check("step.gen", 32'(bus.GenCount), 32'd4);
        pulse(10'(1 << B_DRAW));
        check("step.edit_rsel", 32'(bus.RowSelect), 32'h8);
        check("step.edit_csel", 32'(bus.ColumnSelect), 32'h2);
        check("step.edit_input", 32'(bus.Input), 32'h1);

        // Clear with Start in the same cycle, from RUN
        pulse(10'(1 << B_START));
        check("clr.pre_running", 32'(bus.Running), 32'h1);
        pulse(10'((1 << B_CLEAR) | (1 << B_START)));
        check("clr.rsel", 32'(bus.RowSelect), 32'hF);
        check("clr.csel", 32'(bus.ColumnSelect), 32'hF);
        check("clr.input", 32'(bus.Input), 32'h0);
        check("clr.state", 32'(bus.state), 32'h0);
        check("clr.running", 32'(bus.Running), 32'h0);
        check("clr.gen", 32'(bus.GenCount), 32'd0);
        tick();
        check_idle("clr.after");
        check("clr.after_running", 32'(bus.Running), 32'h0);
        check("clr.row", 32'(bus.CursorRow), 32'd3);
        check("clr.col", 32'(bus.CursorCol), 32'd1);

        // Reset on the strobe cycle of RUN
        pulse(10'(1 << B_START));
        for (int k = 1; k <= 4; k++) tick();
        check("rst.strobe", 32'(bus.state), 32'h1);
        Reset = 1'b1;
        #1;
        check("rst.async_state", 32'(bus.state), 32'h0);
        check("rst.async_running", 32'(bus.Running), 32'h0);
        check("rst.async_gen", 32'(bus.GenCount), 32'd0);
        check("rst.async_row", 32'(bus.CursorRow), 32'd0);
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rst.post_state%0d", k), 32'(bus.state), 32'h0);
            check($sformatf("rst.post_running%0d", k), 32'(bus.Running), 32'h0);
        end
        pulse(10'(1 << B_DRAW));
        check("rst.edit_rsel", 32'(bus.RowSelect), 32'h1);
        check("rst.edit_csel", 32'(bus.ColumnSelect), 32'h1);
        check("rst.edit_input", 32'(bus.Input), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
